// File: rtl/memory_stage.sv
// Memory stage between execute and writeback: issues aligned loads to the data
// cache, extends the returned lane, and registers one result per instruction.
module memory_stage #(
    parameter int ADDRESS_WIDTH    = 64,
    parameter int REGISTER_WIDTH   = 64,
    parameter int REGISTERNO_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_enable,
    input  logic [REGISTER_WIDTH-1:0]   in_alu_result,
    input  logic [REGISTER_WIDTH-1:0]   in_rs2_value,
    input  logic [REGISTERNO_WIDTH-1:0] in_rd_regno,
    input  logic                        in_update_rd_bool,
    input  logic                        in_load_bool,
    input  logic                        in_store_bool,
    input  logic [1:0]                  in_size,
    input  logic                        in_unsigned_bool,
    output logic                        out_stall,
    output logic                        out_dc_req_valid,
    input  logic                        in_dc_req_ready,
    output logic [ADDRESS_WIDTH-1:0]    out_dc_req_addr,
    input  logic                        in_dc_resp_valid,
    input  logic [REGISTER_WIDTH-1:0]   in_dc_resp_data,
    output logic                        out_enable,
    output logic [REGISTER_WIDTH-1:0]   out_alu_result,
    output logic [REGISTER_WIDTH-1:0]   out_mdata,
    output logic [REGISTER_WIDTH-1:0]   out_rs2_value,
    output logic [ADDRESS_WIDTH-1:0]    out_phy_addr,
    output logic [REGISTERNO_WIDTH-1:0] out_rd_regno,
    output logic                        out_mm_load_bool,
    output logic                        out_update_rd_bool,
    output logic                        out_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                      state_q, state_d;
    logic [REGISTER_WIDTH-1:0]   addr_q, addr_d;
    logic [REGISTERNO_WIDTH-1:0] rd_q, rd_d;
    logic [1:0]                  size_q, size_d;
    logic                        uns_q, uns_d;
    logic                        upd_q, upd_d;

    logic                        enable_q, enable_d;
    logic [REGISTER_WIDTH-1:0]   alu_result_q, alu_result_d;
    logic [REGISTER_WIDTH-1:0]   mdata_q, mdata_d;
    logic [REGISTER_WIDTH-1:0]   rs2_value_q, rs2_value_d;
    logic [ADDRESS_WIDTH-1:0]    phy_addr_q, phy_addr_d;
    logic [REGISTERNO_WIDTH-1:0] rd_regno_q, rd_regno_d;
    logic                        mm_load_q, mm_load_d;
    logic                        update_rd_q, update_rd_d;
    logic                        misaligned_q, misaligned_d;
    logic                        misaligned;

    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    // The cache returns the whole doubleword; shift the addressed lane down first.
    function automatic logic [REGISTER_WIDTH-1:0] extend_load(
        input logic [REGISTER_WIDTH-1:0] data,
        input logic [2:0]                off,
        input logic [1:0]                size,
        input logic                      uns
    );
        logic [REGISTER_WIDTH-1:0] lane;
        lane = data >> {off, 3'b000};
        case (size)
            2'd0:    return uns ? {{(REGISTER_WIDTH-8){1'b0}}, lane[7:0]}
                                : {{(REGISTER_WIDTH-8){lane[7]}}, lane[7:0]};
            2'd1:    return uns ? {{(REGISTER_WIDTH-16){1'b0}}, lane[15:0]}
                                : {{(REGISTER_WIDTH-16){lane[15]}}, lane[15:0]};
            2'd2:    return uns ? {{(REGISTER_WIDTH-32){1'b0}}, lane[31:0]}
                                : {{(REGISTER_WIDTH-32){lane[31]}}, lane[31:0]};
            default: return data;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        size_d       = size_q;
        uns_d        = uns_q;
        upd_d        = upd_q;
        enable_d     = 1'b0;
        alu_result_d = alu_result_q;
        mdata_d      = mdata_q;
        rs2_value_d  = rs2_value_q;
        phy_addr_d   = phy_addr_q;
        rd_regno_d   = rd_regno_q;
        mm_load_d    = mm_load_q;
        update_rd_d  = update_rd_q;
        misaligned_d = misaligned_q;
        misaligned   = (in_load_bool | in_store_bool) & is_misaligned(in_alu_result[2:0], in_size);

        case (state_q)
            IDLE: begin
                if (in_enable) begin
                    if (in_load_bool && !misaligned) begin
                        addr_d  = in_alu_result;
                        rd_d    = in_rd_regno;
                        size_d  = in_size;
                        uns_d   = in_unsigned_bool;
                        upd_d   = in_update_rd_bool;
                        state_d = REQ;
                    end else begin
                        // Faulting accesses retire immediately without writing rd.
                        enable_d     = 1'b1;
                        alu_result_d = in_alu_result;
                        rs2_value_d  = in_rs2_value;
                        phy_addr_d   = in_alu_result[ADDRESS_WIDTH-1:0];
                        rd_regno_d   = in_rd_regno;
                        mm_load_d    = 1'b0;
                        update_rd_d  = in_update_rd_bool & ~misaligned;
                        misaligned_d = misaligned;
                    end
                end
            end
            REQ: begin
                if (in_dc_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (in_dc_resp_valid) begin
                    enable_d     = 1'b1;
                    alu_result_d = addr_q;
                    mdata_d      = extend_load(in_dc_resp_data, addr_q[2:0], size_q, uns_q);
                    phy_addr_d   = addr_q[ADDRESS_WIDTH-1:0];
                    rd_regno_d   = rd_q;
                    mm_load_d    = 1'b1;
                    update_rd_d  = upd_q;
                    misaligned_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rd_q         <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            upd_q        <= 1'b0;
            enable_q     <= 1'b0;
            alu_result_q <= '0;
            mdata_q      <= '0;
            rs2_value_q  <= '0;
            phy_addr_q   <= '0;
            rd_regno_q   <= '0;
            mm_load_q    <= 1'b0;
            update_rd_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            upd_q        <= upd_d;
            enable_q     <= enable_d;
            alu_result_q <= alu_result_d;
            mdata_q      <= mdata_d;
            rs2_value_q  <= rs2_value_d;
            phy_addr_q   <= phy_addr_d;
            rd_regno_q   <= rd_regno_d;
            mm_load_q    <= mm_load_d;
            update_rd_q  <= update_rd_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign out_stall          = (state_q != IDLE);
    assign out_dc_req_valid   = (state_q == REQ);
    assign out_dc_req_addr    = {addr_q[ADDRESS_WIDTH-1:3], 3'b000};
    assign out_enable         = enable_q;
    assign out_alu_result     = alu_result_q;
    assign out_mdata          = mdata_q;
    assign out_rs2_value      = rs2_value_q;
    assign out_phy_addr       = phy_addr_q;
    assign out_rd_regno       = rd_regno_q;
    assign out_mm_load_bool   = mm_load_q;
    assign out_update_rd_bool = update_rd_q;
    assign out_misaligned     = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: a driver issues instructions, a dcache responder
// answers loads, and a monitor pops expected results from a scoreboard.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_enable = 1'b0;
    logic [63:0] in_alu_result = '0;
    logic [63:0] in_rs2_value = '0;
    logic [4:0]  in_rd_regno = '0;
    logic        in_update_rd_bool = 1'b0;
    logic        in_load_bool = 1'b0;
    logic        in_store_bool = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned_bool = 1'b0;
    logic        out_stall;
    logic        out_dc_req_valid;
    logic        in_dc_req_ready;
    logic [63:0] out_dc_req_addr;
    logic        in_dc_resp_valid;
    logic [63:0] in_dc_resp_data;
    logic        out_enable;
    logic [63:0] out_alu_result;
    logic [63:0] out_mdata;
    logic [63:0] out_rs2_value;
    logic [63:0] out_phy_addr;
    logic [4:0]  out_rd_regno;
    logic        out_mm_load_bool;
    logic        out_update_rd_bool;
    logic        out_misaligned;

    memory_stage dut (
        .clk(clk), .reset(reset), .in_enable(in_enable),
        .in_alu_result(in_alu_result), .in_rs2_value(in_rs2_value),
        .in_rd_regno(in_rd_regno), .in_update_rd_bool(in_update_rd_bool),
        .in_load_bool(in_load_bool), .in_store_bool(in_store_bool),
        .in_size(in_size), .in_unsigned_bool(in_unsigned_bool),
        .out_stall(out_stall), .out_dc_req_valid(out_dc_req_valid),
        .in_dc_req_ready(in_dc_req_ready), .out_dc_req_addr(out_dc_req_addr),
        .in_dc_resp_valid(in_dc_resp_valid), .in_dc_resp_data(in_dc_resp_data),
        .out_enable(out_enable), .out_alu_result(out_alu_result),
        .out_mdata(out_mdata), .out_rs2_value(out_rs2_value),
        .out_phy_addr(out_phy_addr), .out_rd_regno(out_rd_regno),
        .out_mm_load_bool(out_mm_load_bool), .out_update_rd_bool(out_update_rd_bool),
        .out_misaligned(out_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu, mdata, rs2, phy;
        logic [4:0]  rd;
        logic        mm, upd, mis, chk_md, chk_rs2;
        int          c0, lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_addr_q[$];
    logic [63:0] resp_data_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_min = 0, rdy_max = 0, rsp_min = 0, rsp_max = 0;
    bit garbage = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference load result: pick the byte lane, mask to the access size, sign-adjust.
    function automatic logic [63:0] model_load(input logic [63:0] d, input logic [2:0] off,
                                               input logic [1:0] sz, input logic uns);
        int bits;
        logic [63:0] v;
        if (sz == 2'd3) return d;
        bits = 8 << sz;
        v = (d >> (8 * off)) & ((64'd1 << bits) - 64'd1);
        if (!uns && v[bits-1]) v = v - (64'd1 << bits);
        return v;
    endfunction

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic upd, input logic [63:0] a, input logic [63:0] rs2,
                         input logic [4:0] rd, input logic [63:0] rdata, input int lat);
        exp_t e;
        int guard;
        logic mis;
        guard = 0;
        @(negedge clk);
        while (out_stall && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (out_stall) begin
            checks++;
            failures++;
            $display("FAIL issue_wait actual=stalled required=idle");
        end
        in_enable = 1'b1; in_load_bool = ld; in_store_bool = st; in_size = sz;
        in_unsigned_bool = uns; in_update_rd_bool = upd; in_alu_result = a;
        in_rs2_value = rs2; in_rd_regno = rd;
        mis = (ld || st) && ((int'(a[2:0]) % (1 << sz)) != 0);
        e.alu = a; e.phy = a; e.rd = rd; e.rs2 = rs2; e.mdata = '0;
        e.c0 = cyc; e.lat = lat; e.chk_md = 1'b0; e.chk_rs2 = 1'b0;
        if (ld && !mis) begin
            e.mm = 1'b1; e.upd = upd; e.mis = 1'b0; e.chk_md = 1'b1;
            e.mdata = model_load(rdata, a[2:0], sz, uns);
            exp_addr_q.push_back({a[63:3], 3'b000});
            resp_data_q.push_back(rdata);
        end else begin
            e.mm = 1'b0; e.upd = upd && !mis; e.mis = mis; e.chk_rs2 = 1'b1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_enable = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_stall) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: score every out_enable pulse, and check outputs hold between pulses.
    logic [63:0] last_alu, last_mdata;
    logic [4:0]  last_rd;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_alu = '0; last_mdata = '0; last_rd = '0;
        end else if (out_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_enable actual=1 required=0 alu=%h", out_alu_result);
            end else begin
                e = exp_q.pop_front();
                chk("alu_result", out_alu_result, e.alu);
                chk("phy_addr", out_phy_addr, e.phy);
                chk("rd_regno", {59'd0, out_rd_regno}, {59'd0, e.rd});
                chk("mm_load", {63'd0, out_mm_load_bool}, {63'd0, e.mm});
                chk("update_rd", {63'd0, out_update_rd_bool}, {63'd0, e.upd});
                chk("misaligned", {63'd0, out_misaligned}, {63'd0, e.mis});
                if (e.chk_md) chk("mdata", out_mdata, e.mdata);
                if (e.chk_rs2) chk("rs2_value", out_rs2_value, e.rs2);
                if (e.lat > 0) chk("latency", 64'(cyc - e.c0), 64'(e.lat));
            end
            last_alu = out_alu_result; last_mdata = out_mdata; last_rd = out_rd_regno;
        end else begin
            chk("hold_alu", out_alu_result, last_alu);
            chk("hold_mdata", out_mdata, last_mdata);
            chk("hold_rd", {59'd0, out_rd_regno}, {59'd0, last_rd});
        end
    end

    // Dcache responder: delays ready and response by a random number of cycles.
    initial begin
        int phase, rdy_cnt, rsp_cnt;
        phase = 0; rdy_cnt = 0; rsp_cnt = 0;
        in_dc_req_ready = 1'b0; in_dc_resp_valid = 1'b0; in_dc_resp_data = '0;
        forever begin
            @(negedge clk);
            in_dc_req_ready = 1'b0;
            in_dc_resp_valid = 1'b0;
            if (phase == 2) begin
                if (rsp_cnt == 0) begin
                    in_dc_resp_valid = 1'b1;
                    in_dc_resp_data = (resp_data_q.size() != 0) ? resp_data_q.pop_front()
                                                                : {$urandom, $urandom};
                    phase = 0;
                end else rsp_cnt--;
            end else begin
                if (phase == 0 && out_dc_req_valid) begin
                    rdy_cnt = $urandom_range(rdy_max, rdy_min);
                    phase = 1;
                end
                if (phase == 1) begin
                    chk("req_valid", {63'd0, out_dc_req_valid}, 64'd1);
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req actual=%h required=none", out_dc_req_addr);
                    end else chk("req_addr", out_dc_req_addr, exp_addr_q[0]);
                    if (rdy_cnt == 0) begin
                        in_dc_req_ready = 1'b1;
                        if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
                        rsp_cnt = $urandom_range(rsp_max, rsp_min);
                        phase = 2;
                    end else rdy_cnt--;
                end
                if (garbage && $urandom_range(0, 3) == 0) begin
                    in_dc_resp_valid = 1'b1;
                    in_dc_resp_data = {$urandom, $urandom};
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ld, st;
        int k;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_enable", {63'd0, out_enable}, 64'd0);
        chk("rst_stall", {63'd0, out_stall}, 64'd0);
        chk("rst_req_valid", {63'd0, out_dc_req_valid}, 64'd0);
        chk("rst_req_addr", out_dc_req_addr, 64'd0);
        chk("rst_alu", out_alu_result, 64'd0);
        chk("rst_mdata", out_mdata, 64'd0);
        chk("rst_misaligned", {63'd0, out_misaligned}, 64'd0);

        // ALU op, then loads at minimum latency
        issue(0, 0, 2'd3, 0, 1, 64'h1234, 64'h0, 5'd5, 64'h0, 1);
        @(negedge clk);
        chk("alu_no_stall", {63'd0, out_stall}, 64'd0);
        issue(1, 0, 2'd0, 0, 1, 64'h1003, 64'h0, 5'd6, 64'h0000_0000_8000_0000, 3);
        issue(1, 0, 2'd0, 1, 1, 64'h1003, 64'h0, 5'd6, 64'h0000_0000_8000_0000, 3);
        issue(1, 0, 2'd2, 0, 1, 64'h2004, 64'h0, 5'd7, 64'h89AB_CDEF_0123_4567, 3);
        issue(1, 0, 2'd2, 1, 1, 64'h2004, 64'h0, 5'd7, 64'h89AB_CDEF_0123_4567, 3);
        issue(1, 0, 2'd1, 0, 1, 64'h2006, 64'h0, 5'd8, 64'h8123_4567_89AB_CDEF, 3);
        issue(1, 0, 2'd3, 0, 1, 64'h2008, 64'h0, 5'd9, 64'hFEDC_BA98_7654_3210, 3);
        wait_drain();

        // Ready held low for four cycles while in_enable toggles
        rdy_min = 4; rdy_max = 4;
        issue(1, 0, 2'd3, 0, 1, 64'h4008, 64'h0, 5'd10, 64'h0123_4567_89AB_CDEF, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_held", {63'd0, out_stall}, 64'd1);
            in_enable = (i % 2) == 0; in_load_bool = 1'b0; in_store_bool = 1'b0;
            in_alu_result = {$urandom, $urandom}; in_rd_regno = 5'(i);
            @(posedge clk);
            #1 in_enable = 1'b0;
        end
        wait_drain();
        rdy_min = 0; rdy_max = 0;

        // Misaligned load, store pass-through, back-to-back ALU ops
        issue(1, 0, 2'd1, 0, 1, 64'h1001, 64'h0, 5'd11, 64'h0, 1);
        issue(0, 1, 2'd3, 0, 0, 64'h3000, 64'hDEAD, 5'd0, 64'h0, 1);
        issue(0, 1, 2'd2, 0, 0, 64'h3002, 64'hBEEF, 5'd0, 64'h0, 1);
        for (int i = 0; i < 5; i++)
            issue(0, 0, 2'd3, 0, 1, 64'h100 + 64'(i), 64'(i), 5'(i + 1), 64'h0, 1);
        wait_drain();

        // Reset while waiting for the response; the late response must be dropped
        rsp_min = 3; rsp_max = 3;
        issue(1, 0, 2'd2, 0, 1, 64'h5000, 64'h0, 5'd12, 64'h1111_2222_3333_4444, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_stall", {63'd0, out_stall}, 64'd0);
        chk("rst_wait_enable", {63'd0, out_enable}, 64'd0);
        chk("rst_wait_alu", out_alu_result, 64'd0);
        chk("rst_wait_mdata", out_mdata, 64'd0);
        chk("rst_wait_rd", {59'd0, out_rd_regno}, 64'd0);
        chk("rst_wait_update", {63'd0, out_update_rd_bool}, 64'd0);
        repeat (6) begin
            @(negedge clk);
            chk("stale_resp_enable", {63'd0, out_enable}, 64'd0);
        end

        // Randomized traffic
        rdy_min = 0; rdy_max = 3; rsp_min = 0; rsp_max = 3; garbage = 1'b1;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            ld = (k < 4);
            st = (k >= 4 && k < 6);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(ld, st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 31)), {$urandom, $urandom}, 0);
        end
        wait_drain();
        garbage = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
